rng_axis_tx: RTL

- Drain side of the TRNG word FIFO.
- Pops 33-bit entries {last, data[31:0]} written by the RNG controller.
- Presents them to the DMA engine as an AXI4-Stream master: TLAST is taken from entry bit 32.
- Small internal buffer hides the 1-cycle FIFO read latency, sustains 1 word/cycle under continuous TREADY, and absorbs backpressure without loss.

---
 rtl/rng_pkg.sv | 12 +
 rtl/rng_axis_tx_if.sv | 26 ++
 rtl/rng_axis_tx_buf.sv | 69 ++++++
 rtl/rng_axis_tx.sv | 110 +++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared TRNG word definitions used by the FIFO drain path.
package rng_pkg;

    // FIFO entry as written by the RNG controller: {last, data}
    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } rng_word_t;

    localparam logic [3:0] RNG_TKEEP_ALL = 4'hF;

endpackage

// File: rtl/rng_axis_tx_if.sv
// AXI4-Stream bundle between the TRNG drain and the DMA engine.
interface rng_axis_tx_if;

    logic [31:0] TDATA;
    logic        TVALID;
    logic        TREADY;
    logic        TLAST;
    logic [3:0]  TKEEP;

    modport master (
        output TDATA,
        output TVALID,
        output TLAST,
        output TKEEP,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        input  TLAST,
        input  TKEEP,
        output TREADY
    );

endinterface

// File: rtl/rng_axis_tx_buf.sv
// DEPTH-entry circular buffer with push/pop/occupancy and a synchronous flush.
// Head entry is read straight from storage registers, so the stream outputs
// never see the FIFO read data combinationally.
module rng_axis_buf
    import rng_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  rng_word_t        push_data,
    input  logic             pop,
    output rng_word_t        head,
    output logic [OCC_W-1:0] occ
);

    rng_word_t        mem_q [DEPTH];
    rng_word_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             pop_ok;

    assign pop_ok = pop && (occ_q != '0);
    assign head   = mem_q[rd_ptr_q];
    assign occ    = occ_q;

    // Next buffer state: flush wins, otherwise independent push and pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop_ok);
        end
    end

    // Buffer registers; storage is cleared on reset so TDATA/TLAST start at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/rng_axis_tx.sv
// TRNG word FIFO drain presenting an AXI4-Stream master to the DMA engine.
// Credit logic keeps occupancy plus the in-flight read within DEPTH, so the
// one-cycle FIFO read latency never overflows the output buffer.
// Optional macro RNG_AXIS_STAT_EN adds accepted-word and packet counters;
// without it WORD_CNT and PKT_CNT read 0.
module rng_axis_tx
    import rng_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [32:0]      FIFO_DOUT,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RE,
    input  logic             STOP,
    rng_axis_tx_if.master    M_AXIS,
    output logic             BUSY,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [CNT_W-1:0] PKT_CNT
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credit_used;
    logic             push;
    logic             pop;
    rng_word_t        head;

    // Reads are issued only against registered state, never against TREADY
    always_comb begin
        credit_used = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
        FIFO_RE     = ~FIFO_EMPTY & ~STOP & ~RST
                      & (credit_used < (OCC_W + 1)'(DEPTH));
        inflight_d  = FIFO_RE;
    end

    // In-flight flag: FIFO data arrives the cycle after the read strobe
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // A word returning while STOP is high is dropped, as is any handshake
    assign push = inflight_q & ~STOP;
    assign pop  = M_AXIS.TVALID & M_AXIS.TREADY & ~STOP;

    rng_axis_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .flush     (STOP),
        .push      (push),
        .push_data (rng_word_t'(FIFO_DOUT)),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign M_AXIS.TVALID = (occ != '0);
    assign M_AXIS.TDATA  = head.data;
    assign M_AXIS.TLAST  = head.last;
    assign M_AXIS.TKEEP  = RNG_TKEEP_ALL;
    assign BUSY          = (occ != '0) | inflight_q;

`ifdef RNG_AXIS_STAT_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Count beats the sink accepted; STOP clears both counters
    always_comb begin
        word_cnt_d = word_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (STOP) begin
            word_cnt_d = '0;
            pkt_cnt_d  = '0;
        end else if (pop) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (head.last) begin
                pkt_cnt_d = pkt_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign WORD_CNT = word_cnt_q;
    assign PKT_CNT  = pkt_cnt_q;
`else
    assign WORD_CNT = '0;
    assign PKT_CNT  = '0;
`endif

endmodule
